// File: rtl/mux_scan_ctrl.sv
// Sequences an 8:1 mux through all channels, settling then sampling each, and hands the word off with valid/ready.
// Optional MUX_SCAN_PARITY_EN adds a parity output over the completed word.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic [2:0] sel,
    output logic       en_n,
    input  logic       mux_m,
    input  logic       mux_n,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       err
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sel, w_sel_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_word, w_word_nxt;
    logic       r_err, w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_cnt   <= 4'd0;
            r_word  <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_sel_nxt   = 3'd0;
                    w_cnt_nxt   = LP_SETTLE;
                    w_err_nxt   = 1'b0;
                    w_word_nxt  = 8'h00;
                end
            end
            S_SETTLE: begin
                // Counter value 1 is the last settle cycle for this channel.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_word_nxt[r_sel] = mux_m;
                if (mux_m == mux_n) begin
                    w_err_nxt = 1'b1;
                end
                if (r_sel != 3'd7) begin
                    w_sel_nxt   = r_sel + 3'd1;
                    w_cnt_nxt   = LP_SETTLE;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (word_ready) begin
                    w_state_nxt = S_IDLE;
                    w_sel_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (r_state == S_SAMPLE && w_state_nxt == S_DONE) begin
            r_parity <= ^w_word_nxt;
        end
    end

    assign parity = r_parity;
`endif

    assign busy       = (r_state != S_IDLE);
    assign word_valid = (r_state == S_DONE);
    assign en_n       = !((r_state == S_SETTLE) || (r_state == S_SAMPLE));
    assign sel        = r_sel;
    assign word       = r_word;
    assign err        = r_err;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: behavioural 8:1 mux model with complement output and fault injection.
module tb_mux_scan_ctrl;

    localparam int SC  = 2;
    localparam int LAT = 8 * (SC + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic [2:0] sel;
    logic       en_n;
    logic       mux_m;
    logic       mux_n;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       err;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    logic [7:0] chan;
    logic       force5;
    int         n_vec = 0;
    int         n_err = 0;

    mux_scan_ctrl #(.SETTLE_CYC(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .sel        (sel),
        .en_n       (en_n),
        .mux_m      (mux_m),
        .mux_n      (mux_n),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err        (err)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity     (parity)
`endif
    );

    always #5 clk = ~clk;

    // Enabled mux drives the selected channel; disabled forces 0. mux_n can be tied to mux_m on channel 5.
    assign mux_m = en_n ? 1'b0 : chan[sel];
    assign mux_n = (force5 && sel == 3'd5) ? mux_m : ~mux_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!word_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, n, LAT);
    endtask

    task automatic run_scan(input logic [7:0] ch, input string tag);
        chan  = ch;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(tag);
    endtask

    task automatic handshake();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        word_ready = 1'b0;
        chan       = 8'h00;
        force5     = 1'b0;
        tick();
        chk("rst_sel", sel, 0);
        chk("rst_en_n", en_n, 1);
        chk("rst_word", word, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("rst_parity", parity, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic scan, latency and DONE outputs
        run_scan(8'hA5, "lat_a5");
        chk("a5_word", word, 8'hA5);
        chk("a5_en_n", en_n, 1);
        chk("a5_err", err, 0);
        chk("a5_sel", sel, 7);
        chk("a5_busy", busy, 1);

        // Stall in DONE
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_word", word, 8'hA5);
            chk("stall_valid", word_valid, 1);
            chk("stall_err", err, 0);
        end
        handshake();
        chk("hs_valid", word_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_word", word, 8'hA5);
        chk("hs_sel", sel, 0);
        chk("hs_en_n", en_n, 1);

        // Complement fault on channel 5 sets sticky err
        force5 = 1'b1;
        run_scan(8'h3C, "lat_3c");
        chk("f5_err", err, 1);
        chk("f5_word", word, 8'h3C);
        handshake();
        force5 = 1'b0;
        chan   = 8'h5A;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_word", word, 0);
        chk("clr_en_n", en_n, 0);
        wait_valid("lat_5a");
        chk("5a_word", word, 8'h5A);
        chk("5a_err", err, 0);
        handshake();

        // Reset mid-scan while settling on channel 3
        chan  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (sel != 3'd3 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_sel3", sel, 3);
        chk("sel3_en_n", en_n, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_sel", sel, 0);
        chk("mrst_en_n", en_n, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_word", word, 0);
        chk("mrst_valid", word_valid, 0);
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_accept", busy, 1);
        wait_valid("lat_ff");
        chk("ff_word", word, 8'hFF);
        handshake();

        // start held high through scan and handshake
        chan  = 8'h96;
        start = 1'b1;
        tick();
        wait_valid("lat_hold");
        chk("hold_word", word, 8'h96);
        handshake();
        chk("hold_hs_busy", busy, 0);
        chk("hold_hs_valid", word_valid, 0);
        tick();
        chk("hold_restart", busy, 1);
        chk("hold_restart_sel", sel, 0);
        start = 1'b0;
        wait_valid("lat_hold2");
        chk("hold2_word", word, 8'h96);
        handshake();

`ifdef MUX_SCAN_PARITY_EN
        run_scan(8'h07, "lat_07");
        chk("par_07", parity, 1);
        handshake();
        run_scan(8'h03, "lat_03");
        chk("par_03", parity, 0);
        handshake();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
